// File: rtl/sfifo_if_gen2.sv
// Wishbone slave for the motion sync FIFO, base-period tick, DOUT accumulators and DIN inputs.
// Prefetches one SFIFO word; stalled DI reads end in wb_err_o after TIMEOUT cycles.
module sfifo_if_gen2 #(
   parameter int unsigned WB_AW    = 5,
   parameter int unsigned WB_DW    = 32,
   parameter int unsigned SFIFO_DW = 16,
   parameter int unsigned DOUT_W   = 8,
   parameter int unsigned DIN_W    = 16,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [3:0]          wb_sel_i,
   input  logic [WB_AW-3:0]    wb_adr_i,
   input  logic [WB_DW-1:0]    wb_dat_i,
   output logic [WB_DW-1:0]    wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic                sfifo_rd_o,
   input  logic                sfifo_empty_i,
   input  logic [SFIFO_DW-1:0] sfifo_di,
   input  logic                sfifo_bp_tick_i,
   output logic [DOUT_W-1:0]   dout_set_o,
   output logic [DOUT_W-1:0]   dout_rst_o,
   input  logic [DIN_W-1:0]    din_i
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] AdrBpTick    = 3'd0;
   localparam logic [2:0] AdrStatus    = 3'd1;
   localparam logic [2:0] AdrDi        = 3'd2;
   localparam logic [2:0] AdrDout      = 3'd3;
   localparam logic [2:0] AdrDin       = 3'd4;
   localparam logic [2:0] AdrRise      = 3'd5;
   localparam logic [2:0] AdrFall      = 3'd6;
   localparam logic [2:0] AdrDoutState = 3'd7;

   logic                ack_q, ack_d, err_q, err_d;
   logic [WB_DW-1:0]    dat_q, dat_d;
   logic                rd_q, rd_d, cap_q;
   logic [SFIFO_DW-1:0] buf_q, buf_d;
   logic                bufv_q, bufv_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                sticky_q, sticky_d;
   logic                bp_s1_q, bp_s2_q, bp_prev_q, bp_pulse;
   logic [31:0]         bp_cnt_q, bp_cnt_d;
   logic [DOUT_W-1:0]   set_acc_q, set_acc_d, rst_acc_q, rst_acc_d;
   logic [DOUT_W-1:0]   dout_set_q, dout_set_d, dout_rst_q, dout_rst_d;
   logic [DIN_W-1:0]    din_s1_q, din_s2_q, din_h_q;
   logic [DIN_W-1:0]    rise_q, rise_d, fall_q, fall_d;
   logic                rise_clr, fall_clr;
   logic                req, acc;
   logic                unused_bits;

   assign unused_bits = ^{wb_sel_i[2:0], wb_dat_i[23:2], wb_dat_i[0]};

   assign req      = wb_cyc_i & wb_stb_i;
   // Block acceptance while a response is on the bus so each access sees exactly one.
   assign acc      = req & ~ack_q & ~err_q;
   assign bp_pulse = bp_s2_q & ~bp_prev_q;

   always_comb begin
      ack_d      = 1'b0;
      err_d      = 1'b0;
      dat_d      = '0;
      cnt_d      = cnt_q;
      sticky_d   = sticky_q;
      buf_d      = buf_q;
      bufv_d     = bufv_q;
      bp_cnt_d   = bp_cnt_q;
      set_acc_d  = set_acc_q;
      rst_acc_d  = rst_acc_q;
      dout_set_d = dout_set_q;
      dout_rst_d = dout_rst_q;
      rise_clr   = 1'b0;
      fall_clr   = 1'b0;

      if (cap_q) begin
         buf_d  = sfifo_di;
         bufv_d = 1'b1;
      end

      // Accumulators clear first so a same-cycle command lands in the next period.
      if (bp_pulse) begin
         dout_set_d = set_acc_q;
         dout_rst_d = rst_acc_q;
         set_acc_d  = '0;
         rst_acc_d  = '0;
         bp_cnt_d   = bp_cnt_q + 32'd1;
      end

      if (!req) begin
         cnt_d = '0;
      end

      if (acc) begin
         if (wb_adr_i == AdrDi && !wb_we_i) begin
            if (bufv_q) begin
               ack_d  = 1'b1;
               dat_d  = WB_DW'(buf_q) << (WB_DW - SFIFO_DW);
               bufv_d = 1'b0;
               cnt_d  = '0;
            end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT - 1)) begin
               err_d    = 1'b1;
               sticky_d = 1'b1;
               cnt_d    = '0;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end else begin
            ack_d = 1'b1;
            if (wb_we_i) begin
               if (wb_adr_i == AdrStatus && wb_dat_i[1]) begin
                  sticky_d = 1'b0;
               end
               if (wb_adr_i == AdrDout && wb_sel_i[3] && wb_dat_i[31]) begin
                  for (int unsigned i = 0; i < DOUT_W; i++) begin
                     if (wb_dat_i[29:24] == 6'(i)) begin
                        set_acc_d[i] = wb_dat_i[30];
                        rst_acc_d[i] = ~wb_dat_i[30];
                     end
                  end
               end
            end else begin
               case (wb_adr_i)
                  AdrBpTick:    dat_d = WB_DW'(bp_cnt_q);
                  AdrStatus:    dat_d = WB_DW'({sticky_q, ~bufv_q});
                  AdrDin:       dat_d = WB_DW'(din_s2_q);
                  AdrRise: begin
                     dat_d    = WB_DW'(rise_q);
                     rise_clr = 1'b1;
                  end
                  AdrFall: begin
                     dat_d    = WB_DW'(fall_q);
                     fall_clr = 1'b1;
                  end
                  AdrDoutState: dat_d = WB_DW'(dout_set_q);
                  default:      dat_d = '0;
               endcase
            end
         end
      end

      rise_d = (rise_clr ? '0 : rise_q) | (din_s2_q & ~din_h_q);
      fall_d = (fall_clr ? '0 : fall_q) | (~din_s2_q & din_h_q);

      // One pop outstanding at most: wait out both the pop and the capture cycle.
      rd_d = ~bufv_d & ~rd_q & ~cap_q & ~sfifo_empty_i;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= '0;
         rd_q       <= 1'b0;
         cap_q      <= 1'b0;
         buf_q      <= '0;
         bufv_q     <= 1'b0;
         cnt_q      <= '0;
         sticky_q   <= 1'b0;
         bp_s1_q    <= 1'b1;
         bp_s2_q    <= 1'b1;
         bp_prev_q  <= 1'b1;
         bp_cnt_q   <= '0;
         set_acc_q  <= '0;
         rst_acc_q  <= '0;
         dout_set_q <= '0;
         dout_rst_q <= '0;
         din_s1_q   <= '0;
         din_s2_q   <= '0;
         din_h_q    <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
      end else begin
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         rd_q       <= rd_d;
         cap_q      <= rd_q;
         buf_q      <= buf_d;
         bufv_q     <= bufv_d;
         cnt_q      <= cnt_d;
         sticky_q   <= sticky_d;
         bp_s1_q    <= sfifo_bp_tick_i;
         bp_s2_q    <= bp_s1_q;
         bp_prev_q  <= bp_s2_q;
         bp_cnt_q   <= bp_cnt_d;
         set_acc_q  <= set_acc_d;
         rst_acc_q  <= rst_acc_d;
         dout_set_q <= dout_set_d;
         dout_rst_q <= dout_rst_d;
         din_s1_q   <= din_i;
         din_s2_q   <= din_s1_q;
         din_h_q    <= din_s2_q;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
      end
   end

   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign wb_dat_o   = dat_q;
   assign sfifo_rd_o = rd_q;
   assign dout_set_o = dout_set_q;
   assign dout_rst_o = dout_rst_q;

endmodule

// File: tb/tb_sfifo_if_gen2.sv
// Directed bench for sfifo_if_gen2: bus tasks push expected responses, a monitor pops
// and compares on every ack/err; an SFIFO model serves pops from a queue.
module tb_sfifo_if_gen2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [2:0]  adr = 3'd0;
   logic [31:0] wdat = '0;
   logic [31:0] rdat;
   logic        ack, err, rd;
   logic        sf_empty = 1'b1;
   logic [15:0] sf_di = '0;
   logic        tick = 1'b0;
   logic [7:0]  dset, drst;
   logic [15:0] din = '0;

   int tests = 0;
   int fails = 0;
   int rd_cnt = 0;

   typedef struct packed {
      logic        err;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   string       name_q[$];
   logic [15:0] fq[$];

   sfifo_if_gen2 #(.TIMEOUT(16)) dut (
      .wb_clk_i       (clk),
      .wb_rst_n_i     (rst_n),
      .wb_cyc_i       (cyc),
      .wb_stb_i       (stb),
      .wb_we_i        (we),
      .wb_sel_i       (sel),
      .wb_adr_i       (adr),
      .wb_dat_i       (wdat),
      .wb_dat_o       (rdat),
      .wb_ack_o       (ack),
      .wb_err_o       (err),
      .sfifo_rd_o     (rd),
      .sfifo_empty_i  (sf_empty),
      .sfifo_di       (sf_di),
      .sfifo_bp_tick_i(tick),
      .dout_set_o     (dset),
      .dout_rst_o     (drst),
      .din_i          (din)
   );

   always #5 clk = ~clk;

   // SFIFO model: head word presented the cycle after each pop.
   always @(negedge clk) begin
      if (rst_n && rd) begin
         rd_cnt++;
         if (fq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_on_empty: sfifo_rd_o=1 with model queue empty, required no pop");
         end else begin
            sf_di = fq.pop_front();
         end
      end
      sf_empty = (fq.size() == 0);
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      if (rst_n && (ack || err)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_response: ack=%0b err=%0b dat=%08h, required none",
                     ack, err, rdat);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (err != e.err || ack == e.err || (e.chk && rdat != e.data)) begin
               fails++;
               $display("FAIL %s: got ack=%0b err=%0b dat=%08h, required err=%0b dat=%08h",
                        nm, ack, err, rdat, e.err, e.data);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %08h, required %08h", nm, got, want);
      end
   endtask

   // Called at a negedge; drives immediately, returns at a negedge with the bus idle.
   task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic exp_err, input logic exp_chk,
                      input logic [31:0] exp_dat, input int exp_lat, input string nm);
      int n = 0;
      exp_q.push_back('{err: exp_err, chk: exp_chk, data: exp_dat});
      name_q.push_back(nm);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(ack || err) && n < 100);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
      tests++;
      if (!(ack || err)) begin
         fails++;
         $display("FAIL %s_timeout: no response after %0d cycles, required one", nm, n);
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end else if (n != exp_lat) begin
         fails++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", nm, n, exp_lat);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd_reg(input logic [2:0] a, input logic [31:0] want, input string nm);
      bus(1'b0, a, 32'h0, 4'hF, 1'b0, 1'b1, want, 1, nm);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                         input string nm);
      bus(1'b1, a, d, s, 1'b0, 1'b0, 32'h0, 1, nm);
   endtask

   task automatic bp_pulse(input int hi);
      tick = 1'b1;
      repeat (hi) @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_dat", rdat, 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);
      chk("rst_dset", 32'(dset), 32'h0);
      chk("rst_drst", 32'(drst), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      rd_reg(3'd0, 32'h0, "bp_tick_reset");
      rd_reg(3'd1, 32'h1, "status_reset");
      wr_reg(3'd0, 32'h1234, 4'hF, "wr_ro_bp_tick");
      rd_reg(3'd0, 32'h0, "bp_tick_ro");

      // BP tick counting, including one long-held tick.
      repeat (5) bp_pulse(3);
      bp_pulse(10);
      rd_reg(3'd0, 32'd6, "bp_tick_six");
      force dut.bp_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.bp_cnt_q;
      bp_pulse(3);
      rd_reg(3'd0, 32'h0, "bp_tick_wrap");

      // Prefetched DI reads.
      rd_cnt = 0;
      fq.push_back(16'hA5A5);
      fq.push_back(16'h1234);
      repeat (8) @(negedge clk);
      rd_reg(3'd2, 32'hA5A5_0000, "di_first");
      repeat (8) @(negedge clk);
      rd_reg(3'd2, 32'h1234_0000, "di_second");
      repeat (6) @(negedge clk);
      chk("pop_count", 32'(rd_cnt), 32'd2);
      rd_reg(3'd1, 32'h1, "status_drained");

      // DI timeout on an empty FIFO.
      bus(1'b0, 3'd2, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 16, "di_timeout");
      rd_reg(3'd1, 32'h3, "status_sticky");
      wr_reg(3'd1, 32'h2, 4'hF, "status_clear");
      rd_reg(3'd1, 32'h1, "status_cleared");
      chk("timeout_no_pop", 32'(rd_cnt), 32'd2);

      // DOUT accumulators: last write wins; masked, bad-index and invalid commands ignored.
      wr_reg(3'd3, 32'hC300_0000, 4'h8, "dout_set3");
      wr_reg(3'd3, 32'h8300_0000, 4'h8, "dout_clr3");
      wr_reg(3'd3, 32'hC100_0000, 4'h7, "dout_nosel");
      wr_reg(3'd3, 32'hFF00_0000, 4'h8, "dout_badidx");
      wr_reg(3'd3, 32'h4200_0000, 4'h8, "dout_invalid");
      chk("dout_before_bp", 32'(drst), 32'h0);
      bp_pulse(3);
      chk("dout_set_p1", 32'(dset), 32'h00);
      chk("dout_rst_p1", 32'(drst), 32'h08);

      // Command coinciding with the BP pulse belongs to the next period.
      wr_reg(3'd3, 32'hC500_0000, 4'h8, "dout_set5");
      tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      wr_reg(3'd3, 32'h8000_0000, 4'h8, "dout_same_cycle");
      tick = 1'b0;
      repeat (4) @(negedge clk);
      chk("dout_set_p2", 32'(dset), 32'h20);
      chk("dout_rst_p2", 32'(drst), 32'h00);
      rd_reg(3'd7, 32'h20, "dout_state");
      bp_pulse(3);
      chk("dout_set_p3", 32'(dset), 32'h00);
      chk("dout_rst_p3", 32'(drst), 32'h01);

      // DIN sticky edges.
      din[0] = 1'b1;
      repeat (4) @(negedge clk);
      din[0] = 1'b0;
      repeat (4) @(negedge clk);
      rd_reg(3'd5, 32'h1, "din_rise");
      rd_reg(3'd6, 32'h1, "din_fall");
      rd_reg(3'd5, 32'h0, "din_rise_clr");
      rd_reg(3'd6, 32'h0, "din_fall_clr");
      din = 16'hBEEF;
      repeat (4) @(negedge clk);
      rd_reg(3'd4, 32'h0000_BEEF, "din_value");
      rd_reg(3'd5, 32'h0000_BEEF, "din_rise_multi");
      rd_reg(3'd6, 32'h0, "din_fall_none");

      // Reset asserted in the middle of a stalled DI read.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd2; sel = 4'hF;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack), 32'h0);
      chk("midrst_err", 32'(err), 32'h0);
      chk("midrst_dat", rdat, 32'h0);
      chk("midrst_rd", 32'(rd), 32'h0);
      chk("midrst_dset", 32'(dset), 32'h0);
      chk("midrst_drst", 32'(drst), 32'h0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rd_reg(3'd0, 32'h0, "bp_tick_after_rst");
      rd_reg(3'd1, 32'h1, "status_after_rst");

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
